// File: rtl/fp_wb_intermediate_arbiter.sv
// Intermediate-writeback arbiter feeding one registered slot to normalize/round.
// Define FP_WB_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module fp_wb_intermediate_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int ID_W      = 2,
  parameter int PAYLOAD_W = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             src_done,
  input  logic [NUM_SRC*ID_W-1:0]        src_id,
  input  logic [NUM_SRC*PAYLOAD_W-1:0]   src_payload,
  output logic [NUM_SRC-1:0]             src_ack,
  output logic                           out_valid,
  output logic [ID_W-1:0]                out_id,
  output logic [PAYLOAD_W-1:0]           out_payload,
  input  logic                           out_ready
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                 r_valid;
  logic [ID_W-1:0]      r_id;
  logic [PAYLOAD_W-1:0] r_payload;

  logic                 w_can_load;
  logic                 w_found;
  logic                 w_grant;
  logic [PTR_W-1:0]     w_idx;
  logic [NUM_SRC-1:0]   w_ack;
  logic [ID_W-1:0]      w_sel_id;
  logic [PAYLOAD_W-1:0] w_sel_pl;

  assign w_can_load = ~r_valid | out_ready;
  assign w_grant    = w_found & w_can_load & ~rst;

`ifdef FP_WB_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] r_ptr;

  // Round-robin search starting at the pointer
  always_comb begin
    int k;
    w_found = 1'b0;
    w_idx   = '0;
    k       = 0;
    for (int j = 0; j < NUM_SRC; j++) begin
      k = (int'(r_ptr) + j) % NUM_SRC;
      if (!w_found && src_done[k]) begin
        w_found = 1'b1;
        w_idx   = PTR_W'(k);
      end
    end
  end

  // Pointer moves past the winner, only on a grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= PTR_W'((int'(w_idx) + 1) % NUM_SRC);
    end
  end
`else
  // Fixed priority: lowest index wins
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (!w_found && src_done[j]) begin
        w_found = 1'b1;
        w_idx   = PTR_W'(j);
      end
    end
  end
`endif

  // One-hot grant and winner data select
  always_comb begin
    w_ack    = '0;
    w_sel_id = '0;
    w_sel_pl = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_grant && (int'(w_idx) == i)) begin
        w_ack[i] = 1'b1;
        w_sel_id = src_id[i*ID_W +: ID_W];
        w_sel_pl = src_payload[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  // Output slot: load on grant, drain on ready, data held when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_payload <= '0;
    end else if (w_grant) begin
      r_valid   <= 1'b1;
      r_id      <= w_sel_id;
      r_payload <= w_sel_pl;
    end else if (out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign src_ack     = w_ack;
  assign out_valid   = r_valid;
  assign out_id      = r_id;
  assign out_payload = r_payload;

endmodule
